// File: rtl/mdu_div_iter_pkg.sv
// Shared types for the iterative divider in the EXE-stage multiply/divide unit.
// Holds the FSM state encoding and the latched sign/zero flags of a request.
package mdu_div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } DivStateType;

  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic dz;
  } DivSignType;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract divisor.
// Ports: rem/din/divisor in; rem_next (partial remainder), qbit (quotient bit) out.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;

  assign shifted = {rem, din};

  always_comb begin
    qbit     = (shifted >= {2'b00, divisor});
    rem_next = shifted[WIDTH:0];
    if (qbit)
      rem_next = shifted[WIDTH:0] - {1'b0, divisor};
  end

endmodule

// File: rtl/mdu_div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Ports: clk, rst, Flush, DivStart, DivSigned, Dividend, Divisor in;
//        DivBusy, DivDone, Quotient, Remainder out. Latency WIDTH+2 cycles.
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic             DivStart,
  input  logic             DivSigned,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             DivBusy,
  output logic             DivDone,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  import mdu_div_iter_pkg::*;

  localparam int DIV_CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    DivSignType       sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } DivReqType;

  DivStateType          state;
  DivStateType          state_nxt;
  DivReqType            req;
  DivReqType            req_in;
  logic [WIDTH-1:0]     dvd_orig;
  logic [WIDTH:0]       rem;
  logic [WIDTH:0]       rem_nxt;
  logic                 qbit;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 accept;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  assign DivBusy = (state == DIV_CALC) || (state == DIV_FIX);
  assign DivDone = (state == DIV_DONE);
  assign accept  = DivStart && !Flush &&
                   ((state == DIV_IDLE) || (state == DIV_DONE));

  always_comb begin
    a_neg                = DivSigned && Dividend[WIDTH-1];
    b_neg                = DivSigned && Divisor[WIDTH-1];
    req_in.sign.q_neg    = a_neg ^ b_neg;
    req_in.sign.r_neg    = a_neg;
    req_in.sign.dz       = (Divisor == '0);
    req_in.dividend      = a_neg ? -Dividend : Dividend;
    req_in.divisor       = b_neg ? -Divisor : Divisor;
  end

  // The dividend register doubles as the quotient shift register.
  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .din     (req.dividend[WIDTH-1]),
    .divisor (req.divisor),
    .rem_next(rem_nxt),
    .qbit    (qbit)
  );

  // Divide by zero bypasses sign fix-up: all ones and the raw dividend.
  always_comb begin
    q_fix = req.dividend;
    r_fix = rem[WIDTH-1:0];
    if (req.sign.dz) begin
      q_fix = '1;
      r_fix = dvd_orig;
    end else begin
      if (req.sign.q_neg)
        q_fix = -req.dividend;
      if (req.sign.r_neg)
        r_fix = -rem[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_CALC;
      DIV_CALC: if (cnt == DIV_CNT_W'(1)) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = accept ? DIV_CALC : DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (Flush)
      state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= DIV_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= '0;
      dvd_orig  <= '0;
      rem       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      if (accept) begin
        req      <= req_in;
        dvd_orig <= Dividend;
        rem      <= '0;
        cnt      <= DIV_CNT_W'(WIDTH);
      end else if (state == DIV_CALC) begin
        rem          <= rem_nxt;
        req.dividend <= {req.dividend[WIDTH-2:0], qbit};
        cnt          <= cnt - DIV_CNT_W'(1);
      end
      if ((state == DIV_FIX) && !Flush) begin
        Quotient  <= q_fix;
        Remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Self-checking bench for mdu_div_iter: vector table, scoreboard, corner cases.
// Drives a 32-bit and an 8-bit instance.
module tb_mdu_div_iter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, Flush, DivStart, DivSigned;
  logic [31:0] Dividend, Divisor;
  logic        DivBusy, DivDone;
  logic [31:0] Quotient, Remainder;

  logic        s_rst, s_flush, s_start, s_sgn;
  logic [7:0]  s_a, s_b;
  logic        s_busy, s_done;
  logic [7:0]  s_q, s_r;

  mdu_div_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .Flush(Flush), .DivStart(DivStart),
    .DivSigned(DivSigned), .Dividend(Dividend), .Divisor(Divisor),
    .DivBusy(DivBusy), .DivDone(DivDone),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  mdu_div_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(s_rst), .Flush(s_flush), .DivStart(s_start),
    .DivSigned(s_sgn), .Dividend(s_a), .Divisor(s_b),
    .DivBusy(s_busy), .DivDone(s_done),
    .Quotient(s_q), .Remainder(s_r)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  logic [31:0] last_q, last_r;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.q = '1;
      e.r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (DivDone === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got pulse want none");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", Quotient, mon_e.q);
        chk("remainder", Remainder, mon_e.r);
      end
    end
  end

  task automatic do_op(input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] qe,
                       input logic [31:0] re, input bit armed,
                       input int poke);
    int   lat;
    int   busy_n;
    int   dn;
    exp_t e;
    if (!armed) begin
      @(posedge clk);
      #1;
      DivSigned = sgn;
      Dividend  = a;
      Divisor   = b;
      DivStart  = 1'b1;
    end
    e.q = qe;
    e.r = re;
    sb.push_back(e);
    @(posedge clk);
    #1 DivStart = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (poke > 0 && k == poke) begin
        DivStart = 1'b1;
        Dividend = 32'd77;
        Divisor  = 32'd3;
      end else if (poke > 0 && k == poke + 1) begin
        DivStart = 1'b0;
      end
      if (DivDone) begin
        lat = k;
        break;
      end
      if (DivBusy) busy_n++;
    end
    chk("latency", lat, 32'd34);
    chk("busy_cycles", busy_n, 32'd33);
    chk("busy_at_done", {31'b0, DivBusy}, 32'd0);
    last_q = qe;
    last_r = re;
    if (poke > 0) begin
      dn = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (DivDone) dn++;
      end
      chk("ignored_start", dn, 32'd0);
    end
  endtask

  initial begin
    exp_t        e;
    logic        sg;
    logic [31:0] ra, rb;
    logic [7:0]  a8[2];
    logic [7:0]  b8[2];
    logic [7:0]  q8[2];
    logic [7:0]  r8[2];
    logic        g8[2];
    int          lat;

    rst = 1'b1; Flush = 1'b0; DivStart = 1'b0; DivSigned = 1'b0;
    Dividend = '0; Divisor = '0;
    s_rst = 1'b1; s_flush = 1'b0; s_start = 1'b0; s_sgn = 1'b0;
    s_a = '0; s_b = '0;
    last_q = '0; last_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, DivBusy}, 32'd0);
    chk("rst_done", {31'b0, DivDone}, 32'd0);
    chk("rst_q", Quotient, 32'd0);
    chk("rst_r", Remainder, 32'd0);
    chk("rst8_qr", {16'b0, s_q, s_r}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    s_rst = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5};
    vecs[6] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5};
    vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 300)) : $urandom;
      e  = model(sg, ra, rb);
      do_op(sg, ra, rb, e.q, e.r, 1'b0, 0);
    end

    @(posedge clk);
    #1;
    DivSigned = 1'b0; Dividend = 32'd1000; Divisor = 32'd3; DivStart = 1'b1;
    @(posedge clk);
    #1 DivStart = 1'b0;
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, DivBusy}, 32'd0);
    chk("flush_done", {31'b0, DivDone}, 32'd0);
    chk("flush_q_hold", Quotient, last_q);
    chk("flush_r_hold", Remainder, last_r);
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    @(posedge clk);
    #1;
    Flush = 1'b1; DivStart = 1'b1; Dividend = 32'd8; Divisor = 32'd2;
    @(posedge clk);
    #1 Flush = 1'b0;
    DivStart = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'b0, DivBusy}, 32'd0);

    do_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 12);

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    DivSigned = 1'b1; Dividend = 32'hFFFF_FF9C; Divisor = 32'd7; DivStart = 1'b1;
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1, 0);

    @(posedge clk);
    #1;
    DivSigned = 1'b0; Dividend = 32'd50; Divisor = 32'd5; DivStart = 1'b1;
    @(posedge clk);
    #1 DivStart = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, DivBusy}, 32'd0);
    chk("midrst_q", Quotient, 32'd0);
    chk("midrst_r", Remainder, 32'd0);
    repeat (40) @(negedge clk);

    a8 = '{8'd100, 8'h80};
    b8 = '{8'd7,   8'hFF};
    q8 = '{8'd14,  8'h80};
    r8 = '{8'd2,   8'h00};
    g8 = '{1'b0,   1'b1};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      s_sgn = g8[i]; s_a = a8[i]; s_b = b8[i]; s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (s_done) begin
          lat = k;
          break;
        end
      end
      chk("w8_latency", lat, 32'd10);
      chk("w8_q", {24'b0, s_q}, {24'b0, q8[i]});
      chk("w8_r", {24'b0, s_r}, {24'b0, r8[i]});
    end

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
